// File: rtl/patch_init_loader_if.sv
// Stream-in / init-memory-write bundle for the patch init loader.
// slave  : the loader's view (consumes the grid stream, drives memory and status)
// master : the producer/observer view (drives the grid stream, watches outputs)
interface patch_init_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
);
    logic              start;
    logic [DATA_W-1:0] in_data;      // 1.17 fixed-point node value (two's complement bits)
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              solver_reset;
    logic              load_done;
    logic              err_len;

    modport master (
        output start, in_data, in_valid, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, solver_reset, load_done, err_len
    );

    modport slave (
        input  start, in_data, in_valid, in_last,
        output in_ready, wr_en, wr_addr, wr_data, solver_reset, load_done, err_len
    );
endinterface

// File: rtl/patch_init_loader.sv
// Patch init loader: accepts a row-major 24x24 grid of node displacements and
// writes each value into the patch-major init memory of the drum solver.
// Address generation uses four cascaded wrap counters (no dividers). The solver
// is held in reset until a complete frame has landed in memory.
module patch_init_loader #(
    parameter int PATCH_NUM           = 36,
    parameter int PATCH_NUM_DIMENSION = 6,
    parameter int PATCH_SIZE          = 4,
    parameter int ADDR_W              = 10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    patch_init_loader_if.slave io_bus
);
    localparam int DATA_W = 18;
    localparam int CL_W   = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
    localparam int CP_W   = (PATCH_NUM_DIMENSION > 1) ? $clog2(PATCH_NUM_DIMENSION) : 1;

    localparam logic [CL_W-1:0]   CL_MAX    = CL_W'(PATCH_SIZE - 1);
    localparam logic [CP_W-1:0]   CP_MAX    = CP_W'(PATCH_NUM_DIMENSION - 1);
    localparam logic [CL_W-1:0]   CL_ZERO   = {CL_W{1'b0}};
    localparam logic [CP_W-1:0]   CP_ZERO   = {CP_W{1'b0}};
    localparam logic [CL_W-1:0]   CL_ONE    = CL_W'(1);
    localparam logic [CP_W-1:0]   CP_ONE    = CP_W'(1);
    // The final grid node always maps to the highest patch-major address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PATCH_NUM * PATCH_SIZE * PATCH_SIZE - 1);

    // S_FLUSH is the cycle in which the final write is visible on the memory
    // port; the solver is released only on the following cycle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [CL_W-1:0]   r_col_local, r_row_local, w_col_local, w_row_local;
    logic [CP_W-1:0]   r_col_patch, r_row_patch, w_col_patch, w_row_patch;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_solver_reset;
    logic              r_load_done;
    logic              r_err_len;
    logic              w_err_len;

    logic              w_accept;
    logic              w_take;
    logic              w_last_pos;
    logic [ADDR_W-1:0] w_addr;

    // A beat is accepted only while loading; a simultaneous start drops it.
    assign w_accept = io_bus.in_valid & (r_state == S_LOAD);
    assign w_take   = w_accept & ~io_bus.start;

    // Patch-major address of the current grid position.
    assign w_addr = ((ADDR_W'(r_row_patch) * ADDR_W'(PATCH_NUM_DIMENSION) + ADDR_W'(r_col_patch))
                     * ADDR_W'(PATCH_SIZE * PATCH_SIZE))
                  + ADDR_W'(r_row_local) * ADDR_W'(PATCH_SIZE)
                  + ADDR_W'(r_col_local);

    assign w_last_pos = (w_addr == LAST_ADDR);

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start always (re)enters LOAD; a frame ends on the last grid node or an early in_last.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (io_bus.start) begin
                    w_next_state = S_LOAD;
                end else if (w_take && w_last_pos) begin
                    w_next_state = S_FLUSH;
                end else if (w_take && io_bus.in_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_FLUSH: begin
                if (io_bus.start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: next values of the grid counters and the sticky length-error flag.
    always_comb begin
        w_col_local = r_col_local;
        w_col_patch = r_col_patch;
        w_row_local = r_row_local;
        w_row_patch = r_row_patch;
        w_err_len   = r_err_len;
        if (io_bus.start) begin
            w_col_local = CL_ZERO;
            w_col_patch = CP_ZERO;
            w_row_local = CL_ZERO;
            w_row_patch = CP_ZERO;
            w_err_len   = 1'b0;
        end else if (w_take) begin
            if (w_last_pos || io_bus.in_last) begin
                // Frame ends here; length is wrong if in_last and the final node disagree.
                w_col_local = CL_ZERO;
                w_col_patch = CP_ZERO;
                w_row_local = CL_ZERO;
                w_row_patch = CP_ZERO;
                w_err_len   = r_err_len | (w_last_pos ^ io_bus.in_last);
            end else if (r_col_local != CL_MAX) begin
                w_col_local = r_col_local + CL_ONE;
            end else if (r_col_patch != CP_MAX) begin
                w_col_local = CL_ZERO;
                w_col_patch = r_col_patch + CP_ONE;
            end else if (r_row_local != CL_MAX) begin
                w_col_local = CL_ZERO;
                w_col_patch = CP_ZERO;
                w_row_local = r_row_local + CL_ONE;
            end else if (r_row_patch != CP_MAX) begin
                w_col_local = CL_ZERO;
                w_col_patch = CP_ZERO;
                w_row_local = CL_ZERO;
                w_row_patch = r_row_patch + CP_ONE;
            end else begin
                w_col_local = CL_ZERO;
                w_col_patch = CP_ZERO;
                w_row_local = CL_ZERO;
                w_row_patch = CP_ZERO;
            end
        end else begin
            w_err_len = r_err_len;
        end
    end

    // Registered outputs, write port and counters; status follows the next state so it lines up with it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_in_ready     <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= {ADDR_W{1'b0}};
            r_wr_data      <= {DATA_W{1'b0}};
            r_solver_reset <= 1'b1;
            r_load_done    <= 1'b0;
            r_err_len      <= 1'b0;
            r_col_local    <= CL_ZERO;
            r_col_patch    <= CP_ZERO;
            r_row_local    <= CL_ZERO;
            r_row_patch    <= CP_ZERO;
        end else begin
            r_in_ready     <= (w_next_state == S_LOAD);
            r_wr_en        <= w_take;
            if (w_take) begin
                r_wr_addr <= w_addr;
                r_wr_data <= io_bus.in_data;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
            end
            r_solver_reset <= (w_next_state != S_DONE);
            r_load_done    <= (w_next_state == S_DONE);
            r_err_len      <= w_err_len;
            r_col_local    <= w_col_local;
            r_col_patch    <= w_col_patch;
            r_row_local    <= w_row_local;
            r_row_patch    <= w_row_patch;
        end
    end

    assign io_bus.in_ready     = r_in_ready;
    assign io_bus.wr_en        = r_wr_en;
    assign io_bus.wr_addr      = r_wr_addr;
    assign io_bus.wr_data      = r_wr_data;
    assign io_bus.solver_reset = r_solver_reset;
    assign io_bus.load_done    = r_load_done;
    assign io_bus.err_len      = r_err_len;
endmodule
